mbist_march_ctrl: RTL and testbench

MBIST_MARCH_CTRL -- requirements
Module: mbist_march_ctrl

---
 rtl/mbist_march_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_mbist_march_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mbist_march_ctrl.sv
`default_nettype none
// mbist_march_ctrl: March C- memory BIST sequencer with one-shot repair request
// and sticky done/fail status. Rev 1.0
module mbist_march_ctrl #(
  parameter int BIST_ADDR_WD = 9,
  parameter int BIST_DATA_WD = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    bist_run,
  input  logic [BIST_DATA_WD-1:0] bist_rdata,
  output logic                    bist_en,
  output logic [BIST_ADDR_WD-1:0] bist_addr,
  output logic [BIST_DATA_WD-1:0] bist_wdata,
  output logic                    bist_wr,
  output logic                    bist_rd,
  output logic                    bist_error,
  output logic [BIST_ADDR_WD-1:0] bist_error_addr,
  output logic                    bist_done,
  output logic                    bist_fail
);

  localparam logic [BIST_ADDR_WD-1:0] ADDR_LAST = '1;
  localparam logic [BIST_ADDR_WD-1:0] ADDR_ONE  = {{(BIST_ADDR_WD-1){1'b0}}, 1'b1};
  localparam logic [2:0]              ELEM_LAST = 3'd5;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

  state_t                  state_q;
  logic [2:0]              elem_q;
  logic [BIST_ADDR_WD-1:0] addr_q;
  logic                    err_seen_q;
  logic                    cmp_vld_q;
  logic                    cmp_bg_q;
  logic [BIST_ADDR_WD-1:0] cmp_addr_q;
  logic                    en_q;
  logic                    wr_q;
  logic                    rd_q;
  logic [BIST_DATA_WD-1:0] wdata_q;
  logic                    error_q;
  logic [BIST_ADDR_WD-1:0] err_addr_q;
  logic                    done_q;
  logic                    fail_q;

  logic [2:0]              elem_d;
  logic [BIST_ADDR_WD-1:0] addr_d;
  logic                    rd_phase_d;
  logic                    wbg_d;
  logic                    elem_down;
  logic                    elem_two_op;
  logic                    elem_end;
  logic                    march_end;
  logic                    exp_bg;
  logic                    mismatch;

  // Next operation of the march; rd_q doubles as the R/W phase of the current op.
  always_comb begin
    elem_down   = (elem_q >= 3'd3);
    elem_two_op = (elem_q != 3'd0) && (elem_q != ELEM_LAST);
    elem_end    = elem_down ? (addr_q == '0) : (addr_q == ADDR_LAST);
    exp_bg      = (elem_q == 3'd2) || (elem_q == 3'd4);
    elem_d      = elem_q;
    addr_d      = addr_q;
    rd_phase_d  = 1'b1;
    march_end   = 1'b0;
    if (elem_two_op && rd_q) begin
      rd_phase_d = 1'b0;
    end else if (elem_end) begin
      if (elem_q == ELEM_LAST) begin
        march_end = 1'b1;
      end else begin
        elem_d = elem_q + 3'd1;
        addr_d = (elem_q >= 3'd2) ? ADDR_LAST : '0;
      end
    end else begin
      addr_d     = elem_down ? (addr_q - ADDR_ONE) : (addr_q + ADDR_ONE);
      rd_phase_d = (elem_q != 3'd0);
    end
    wbg_d    = (elem_d == 3'd1) || (elem_d == 3'd3);
    mismatch = cmp_vld_q && (bist_rdata != {BIST_DATA_WD{cmp_bg_q}});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      elem_q     <= '0;
      addr_q     <= '0;
      err_seen_q <= 1'b0;
      cmp_vld_q  <= 1'b0;
      cmp_bg_q   <= 1'b0;
      cmp_addr_q <= '0;
      en_q       <= 1'b0;
      wr_q       <= 1'b0;
      rd_q       <= 1'b0;
      wdata_q    <= '0;
      error_q    <= 1'b0;
      err_addr_q <= '0;
      done_q     <= 1'b0;
      fail_q     <= 1'b0;
    end else begin
      error_q   <= 1'b0;
      cmp_vld_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bist_run) begin
            state_q    <= RUN;
            en_q       <= 1'b1;
            done_q     <= 1'b0;
            fail_q     <= 1'b0;
            err_seen_q <= 1'b0;
            elem_q     <= '0;
            addr_q     <= '0;
            wr_q       <= 1'b1;
            rd_q       <= 1'b0;
            wdata_q    <= '0;
          end
        end
        RUN, DRAIN: begin
          if (!bist_run) begin
            state_q    <= IDLE;
            en_q       <= 1'b0;
            wr_q       <= 1'b0;
            rd_q       <= 1'b0;
            done_q     <= 1'b0;
            err_seen_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
          end else if (mismatch && err_seen_q) begin
            state_q <= DONE;
            en_q    <= 1'b0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            done_q  <= 1'b1;
            fail_q  <= 1'b1;
            addr_q  <= '0;
            wdata_q <= '0;
          end else if (mismatch) begin
            // Request repair and restart; the compare due next cycle is dropped.
            state_q    <= RUN;
            error_q    <= 1'b1;
            err_addr_q <= cmp_addr_q;
            err_seen_q <= 1'b1;
            elem_q     <= '0;
            addr_q     <= '0;
            wr_q       <= 1'b1;
            rd_q       <= 1'b0;
            wdata_q    <= '0;
          end else if (state_q == DRAIN) begin
            state_q <= DONE;
            en_q    <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            cmp_vld_q  <= rd_q;
            cmp_bg_q   <= exp_bg;
            cmp_addr_q <= addr_q;
            if (march_end) begin
              state_q <= DRAIN;
              wr_q    <= 1'b0;
              rd_q    <= 1'b0;
            end else begin
              elem_q  <= elem_d;
              addr_q  <= addr_d;
              wr_q    <= ~rd_phase_d;
              rd_q    <= rd_phase_d;
              wdata_q <= {BIST_DATA_WD{wbg_d}};
            end
          end
        end
        DONE: begin
          if (!bist_run) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bist_en         = en_q;
  assign bist_addr       = addr_q;
  assign bist_wdata      = wdata_q;
  assign bist_wr         = wr_q;
  assign bist_rd         = rd_q;
  assign bist_error      = error_q;
  assign bist_error_addr = err_addr_q;
  assign bist_done       = done_q;
  assign bist_fail       = fail_q;

endmodule
`default_nettype wire

// File: tb/tb_mbist_march_ctrl.sv
`timescale 1ns/100ps
`default_nettype none
// tb_mbist_march_ctrl: fault-injecting SRAM model plus abstract March C- reference.
module tb_mbist_march_ctrl;

  localparam int AW = 4;
  localparam int DW = 32;
  localparam int N = 16;
  localparam int NOPS = 10 * N;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          bist_run = 1'b0;
  logic [DW-1:0] bist_rdata;
  logic          bist_en, bist_wr, bist_rd, bist_error, bist_done, bist_fail;
  logic [AW-1:0] bist_addr, bist_error_addr;
  logic [DW-1:0] bist_wdata;

  mbist_march_ctrl #(.BIST_ADDR_WD(AW), .BIST_DATA_WD(DW)) dut (
    .clk(clk), .rst_n(rst_n), .bist_run(bist_run), .bist_rdata(bist_rdata),
    .bist_en(bist_en), .bist_addr(bist_addr), .bist_wdata(bist_wdata),
    .bist_wr(bist_wr), .bist_rd(bist_rd), .bist_error(bist_error),
    .bist_error_addr(bist_error_addr), .bist_done(bist_done), .bist_fail(bist_fail)
  );

  always #5 clk = ~clk;

  typedef struct {logic wr; logic [AW-1:0] addr; logic bg;} op_t;
  typedef struct {logic wr; logic [AW-1:0] addr; logic [DW-1:0] wdata;} dop_t;
  typedef struct {int nflt; int a1; int b1; bit p1; int a2; int b2; bit p2;
                  bit e_fail; int e_nerr; int e_eaddr;} vec_t;

  op_t           march[$];
  op_t           exp_ops[$];
  dop_t          got_ops[$];
  logic [DW-1:0] s0[N], s1[N];
  logic [DW-1:0] mem[N];
  logic          rep[N];
  logic          rep_clr = 1'b1;
  int            n_tests = 0, n_fail = 0;
  int            exp_nerr, exp_done_cnt;
  bit            exp_fail;
  logic [AW-1:0] exp_eaddr;
  vec_t          tab[6];

  // Ideal 1-cycle SRAM; a repaired address is remapped to a fault-free cell.
  always @(posedge clk) begin
    if (rep_clr) for (int i = 0; i < N; i++) rep[i] <= 1'b0;
    else if (bist_error) rep[bist_error_addr] <= 1'b1;
    if (bist_wr) mem[bist_addr] <= bist_wdata;
    if (bist_rd) bist_rdata <= rep[bist_addr] ? mem[bist_addr]
                              : ((mem[bist_addr] & ~s0[bist_addr]) | s1[bist_addr]);
  end

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [45:0] outs();
    return {bist_en, bist_addr, bist_wdata, bist_wr, bist_rd, bist_error,
            bist_error_addr, bist_done, bist_fail};
  endfunction

  function automatic void build_march();
    march.delete();
    for (int a = 0; a < N; a++) march.push_back('{1'b1, AW'(a), 1'b0});
    for (int a = 0; a < N; a++) begin march.push_back('{1'b0, AW'(a), 1'b0}); march.push_back('{1'b1, AW'(a), 1'b1}); end
    for (int a = 0; a < N; a++) begin march.push_back('{1'b0, AW'(a), 1'b1}); march.push_back('{1'b1, AW'(a), 1'b0}); end
    for (int a = N-1; a >= 0; a--) begin march.push_back('{1'b0, AW'(a), 1'b0}); march.push_back('{1'b1, AW'(a), 1'b1}); end
    for (int a = N-1; a >= 0; a--) begin march.push_back('{1'b0, AW'(a), 1'b1}); march.push_back('{1'b1, AW'(a), 1'b0}); end
    for (int a = N-1; a >= 0; a--) march.push_back('{1'b0, AW'(a), 1'b0});
  endfunction

  // Walks the march over an abstract faulty memory: first miscompare repairs and
  // restarts after the one in-flight op, second miscompare ends the run as failed.
  function automatic void model_run();
    logic [DW-1:0] m[N];
    bit            r[N];
    bit            seen = 1'b0;
    int            pos = 0, gaps = 0, idx;
    op_t           op;
    logic [DW-1:0] v;
    for (int i = 0; i < N; i++) begin m[i] = '0; r[i] = 1'b0; end
    exp_ops.delete(); exp_nerr = 0; exp_fail = 1'b0; exp_eaddr = '0; exp_done_cnt = 0;
    while (exp_ops.size() < 4000) begin
      if (pos == NOPS) begin exp_done_cnt = exp_ops.size() + 2 + gaps; return; end
      op = march[pos];
      exp_ops.push_back(op);
      if (op.wr) m[op.addr] = {DW{op.bg}};
      else begin
        v = r[op.addr] ? m[op.addr] : ((m[op.addr] & ~s0[op.addr]) | s1[op.addr]);
        if (v != {DW{op.bg}}) begin
          idx = exp_ops.size() - 1;
          if (pos + 1 < NOPS) begin
            exp_ops.push_back(march[pos+1]);
            if (march[pos+1].wr) m[march[pos+1].addr] = {DW{march[pos+1].bg}};
          end
          if (seen) begin exp_fail = 1'b1; exp_done_cnt = idx + 3 + gaps; return; end
          if (pos + 1 >= NOPS) gaps++;
          seen = 1'b1; exp_nerr++; exp_eaddr = op.addr; r[op.addr] = 1'b1; pos = 0;
          continue;
        end
      end
      pos++;
    end
  endfunction

  function automatic int first_diff();
    int n = (got_ops.size() < exp_ops.size()) ? got_ops.size() : exp_ops.size();
    for (int i = 0; i < n; i++)
      if (got_ops[i].wr !== exp_ops[i].wr || got_ops[i].addr !== exp_ops[i].addr ||
          (exp_ops[i].wr && got_ops[i].wdata !== {DW{exp_ops[i].bg}})) return i;
    if (got_ops.size() != exp_ops.size()) return n;
    return -1;
  endfunction

  task automatic set_faults(input vec_t v);
    for (int i = 0; i < N; i++) begin s0[i] = '0; s1[i] = '0; end
    if (v.nflt >= 1) begin if (v.p1) s1[v.a1][v.b1] = 1'b1; else s0[v.a1][v.b1] = 1'b1; end
    if (v.nflt >= 2) begin if (v.p2) s1[v.a2][v.b2] = 1'b1; else s0[v.a2][v.b2] = 1'b1; end
  endtask

  task automatic run_and_check(input string tag, input bit has_tab, input vec_t v);
    int cnt = 0, nerr = 0, both = 0;
    logic [AW-1:0] eaddr = '0;
    model_run();
    got_ops.delete();
    @(negedge clk) rep_clr = 1'b1;
    @(negedge clk) begin rep_clr = 1'b0; bist_run = 1'b1; end
    forever begin
      @(posedge clk); #1;
      cnt++;
      if (bist_wr && bist_rd) both++;
      if (bist_wr || bist_rd) got_ops.push_back('{bist_wr, bist_addr, bist_wdata});
      if (bist_error) begin nerr++; eaddr = bist_error_addr; end
      if (bist_done) break;
      if (cnt >= 3000) begin
        n_tests++; n_fail++;
        $display("FAIL %s timeout: got no done after %0d cycles", tag, cnt);
        break;
      end
    end
    chk($sformatf("%s done_cycles", tag), cnt, exp_done_cnt);
    chk($sformatf("%s op_stream_first_diff", tag), first_diff(), -1);
    chk($sformatf("%s both_strobes", tag), both, 0);
    chk($sformatf("%s error_pulses", tag), nerr, exp_nerr);
    chk($sformatf("%s fail", tag), bist_fail, exp_fail);
    chk($sformatf("%s en_at_done", tag), {bist_en, bist_wr, bist_rd}, 3'b000);
    if (exp_nerr > 0) chk($sformatf("%s error_addr", tag), eaddr, exp_eaddr);
    if (has_tab) begin
      chk($sformatf("%s tab_fail", tag), bist_fail, v.e_fail);
      chk($sformatf("%s tab_nerr", tag), nerr, v.e_nerr);
      if (v.e_nerr > 0) chk($sformatf("%s tab_eaddr", tag), bist_error_addr, v.e_eaddr);
    end
    repeat (3) @(posedge clk);
    #1 chk($sformatf("%s done_hold", tag), {bist_done, bist_fail, bist_en}, {1'b1, exp_fail, 1'b0});
    @(negedge clk) bist_run = 1'b0;
    @(posedge clk); #1;
    chk($sformatf("%s idle_keeps_status", tag), {bist_done, bist_fail, bist_en}, {1'b1, exp_fail, 1'b0});
  endtask

  initial begin
    vec_t v;
    build_march();
    //         nflt a1 b1 p1  a2 b2 p2  fail nerr eaddr
    tab[0] = '{0,   0, 0, 0,  0, 0, 0,  0,   0,   0};
    tab[1] = '{1,   5, 3, 0,  0, 0, 0,  0,   1,   5};
    tab[2] = '{2,   5, 3, 0,  9, 3, 0,  1,   1,   5};
    tab[3] = '{1,   0,31, 1,  0, 0, 0,  0,   1,   0};
    tab[4] = '{2,  12, 7, 0,  3, 0, 1,  1,   1,   3};
    tab[5] = '{1,  15, 0, 1,  0, 0, 0,  0,   1,  15};
    set_faults(tab[0]);

    repeat (3) @(posedge clk);
    #1 chk("reset_outputs", outs(), '0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1 chk("idle_after_reset", outs(), '0);

    run_and_check("clean", 1'b1, tab[0]);
    chk("e3_op0", {got_ops[80].wr, got_ops[80].addr}, {1'b0, 4'd15});
    chk("e3_op1", {got_ops[81].wr, got_ops[81].addr, got_ops[81].wdata}, {1'b1, 4'd15, 32'hFFFF_FFFF});
    chk("e3_op2", {got_ops[82].wr, got_ops[82].addr}, {1'b0, 4'd14});
    chk("e5_last", {got_ops[159].wr, got_ops[159].addr}, {1'b0, 4'd0});

    for (int i = 1; i < 6; i++) begin
      set_faults(tab[i]);
      run_and_check($sformatf("tab%0d", i), 1'b1, tab[i]);
    end

    for (int i = 0; i < 10; i++) begin
      v = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      v.nflt = $urandom_range(0, 2);
      v.a1 = $urandom_range(0, N-1);
      v.a2 = (v.a1 + $urandom_range(1, N-1)) % N;
      v.b1 = $urandom_range(0, DW-1);
      v.b2 = $urandom_range(0, DW-1);
      v.p1 = 1'($urandom_range(0, 1));
      v.p2 = 1'($urandom_range(0, 1));
      set_faults(v);
      run_and_check($sformatf("rand%0d", i), 1'b0, v);
    end

    // Abort in E2, then a clean rerun.
    set_faults(tab[0]);
    @(negedge clk) bist_run = 1'b1;
    repeat (16 + 32 + 10) @(posedge clk);
    @(negedge clk) bist_run = 1'b0;
    @(posedge clk); #1 chk("abort_e2", {bist_en, bist_wr, bist_rd, bist_done, bist_error}, 5'b0);
    run_and_check("rerun_after_abort", 1'b0, tab[0]);

    // Asynchronous reset mid-E4: outputs clear with no clock edge.
    set_faults(tab[1]);
    run_and_check("pre_reset_fault", 1'b0, tab[1]);
    set_faults(tab[0]);
    @(negedge clk) bist_run = 1'b1;
    repeat (16 + 32 + 32 + 32 + 8) @(posedge clk);
    @(negedge clk);
    #1 begin rst_n = 1'b0; bist_run = 1'b0; end
    #0.5 chk("async_reset_outputs", outs(), '0);
    #0.5 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1 chk("idle_until_run", outs(), '0);
    run_and_check("run_after_reset", 1'b0, tab[0]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
